roachf_2048ch_seed_noise_gen: RTL and testbench
===============================================

# roachf_2048ch_seed_noise_gen

Pseudo-random noise source for the 2048-channel F-engine test-vector path; it consumes the 32-bit seed written by software into the control seed register. It re-seeds a maximal-length 32-bit Galois LFSR only on a frame sync, so seeding is deterministic across boards. Each enabled cycle it emits one 8-bit two's-complement noise sample, with a channel index and a sync aligned to that sample. It sits between the seed software register and the noise-injection mux ahead of the PFB/FFT.

## Interface
- N_CHAN, 2048, channels per spectrum; channel index wraps at N_CHAN-1 (power of two)
- CH_W, 11, width of chan_idx, log2(N_CHAN)
- TAP_MASK, 32'h80200003, Galois feedback mask (polynomial x^32+x^22+x^2+x+1)
- user_clk  in  1  sole clock; also clocks the seed register output
- user_rst_n  in  1  reset, synchronous, active-low
- seed_data  in  32  seed from software register, already in user_clk domain, quasi-static
- sync_in  in  1  frame sync pulse, one cycle high
- en  in  1  LFSR step enable
- noise_out  out  8  current LFSR bits [7:0], two's complement
- valid_out  out  1  en registered; marks noise_out as a fresh sample
- sync_out  out  1  sync_in registered (1-cycle latency)
- chan_idx  out  CH_W  channel index of the current noise_out
- seed_loaded  out  1  one-cycle pulse when a new seed enters the LFSR
- seed_pending  out  1  a changed seed is waiting for the next sync_in

## Operation
- Seed capture: seed_q1 <= seed_data; seed_q2 <= seed_q1.
  - Change is qualified when seed_q1 == seed_q2 and seed_q2 != loaded_seed.
  - On qualification: pending_seed <= seed_q2 and seed_pending <= 1.
  - A later qualified change overwrites pending_seed; last value wins.
- Seed load: on a cycle with sync_in=1 and seed_pending=1:
  - lfsr <= eff(pending_seed), where eff(0) = 32'h00000001 (LFSR lock-up guard) and eff(x) = x otherwise.
  - loaded_seed <= pending_seed.
  - seed_pending <= 0.
  - seed_loaded <= 1 for one cycle.
  - The load takes priority over the LFSR step in that cycle.
  - If a new qualification happens in the same cycle as the load, the load uses the old pending_seed. The new value re-qualifies next cycle, because it differs from the updated loaded_seed.
- LFSR step when en=1 and no load: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAP_MASK : 0). When en=0 the LFSR holds.
- noise_out = lfsr[7:0]. The LFSR is the output register; there is no extra stage.
- valid_out <= en.
- Channel counter:
  - Free-running every cycle, regardless of en.
  - sync_in=1 sets chan_idx to 0 on the next cycle.
  - Otherwise chan_idx increments and wraps from N_CHAN-1 to 0.
- Reset (user_rst_n=0 at a clock edge) applies these values:
  - lfsr = 32'h00000001, so noise_out = 8'h01.
  - loaded_seed, pending_seed, seed_q1 and seed_q2 = 0.
  - seed_pending, seed_loaded, valid_out and sync_out = 0.
  - chan_idx = 0.
- Reset mid-operation discards any pending seed. The seed register's reset value of 0 then matches loaded_seed, so no spurious load occurs.

## Timing
- Latency from seed_data change to seed_pending high: 3 cycles (two capture stages plus the pending register), provided the value is stable.
- A seed that changes every cycle never qualifies, and seed_pending stays low.
- sync_in at cycle t gives, at t+1:
  - sync_out = 1 and chan_idx = 0.
  - If a seed was pending: noise_out = eff(seed)[7:0] and seed_loaded = 1.
- The first stepped value after a load appears at t+2, if en=1 at t+1.
- sync_in without a pending seed gives, at t+1: sync_out = 1 and chan_idx = 0; the LFSR is untouched.
- Back-to-back sync_in pulses are legal; each one realigns chan_idx.
- sync_in during reset is ignored.

## Test plan
- Reset, en=1, no sync → noise sequence 01, 03 (lfsr 0x80200003), 02 (lfsr 0xC0300002); valid_out high from the first cycle after en; chan_idx 0, 1, 2, … wraps 2047 → 0.
- Write seed_data=0xDEADBEEF, then sync_in 5 cycles later → seed_pending rises 3 cycles after the write; the cycle after sync: sync_out=1, seed_loaded=1, noise_out=0xEF, chan_idx=0; seed_pending cleared.
- Write 0x00000000 after 0x12345678 was loaded, then sync → lfsr=0x00000001, noise_out=0x01; the next step gives 0x03.
- Change seed to 0xA5A5A5A5, but no sync for 10,000 cycles → no load and seed_pending held high; the LFSR sequence is unaffected.
- Qualification of 0x2 coinciding with a sync that loads pending 0x1 → load uses 0x1; seed_pending re-asserts next cycle with 0x2; the following sync loads 0x2.
- en=0 for 4 cycles → noise_out constant, valid_out=0, chan_idx still increments.
- Assert user_rst_n=0 while a seed is pending → all outputs return to reset values; the pending seed is discarded.

Source files
------------

// File: rtl/roachf_2048ch_seed_noise_gen.sv
// rtl/roachf_2048ch_seed_noise_gen.sv - seeded 32-bit Galois LFSR noise source with channel index and sync
module roachf_2048ch_seed_noise_gen #(
    parameter int          N_CHAN   = 2048,
    parameter int          CH_W     = 11,
    parameter logic [31:0] TAP_MASK = 32'h80200003
) (
    input  logic            user_clk,
    input  logic            user_rst_n,
    input  logic [31:0]     seed_data,
    input  logic            sync_in,
    input  logic            en,
    output logic [7:0]      noise_out,
    output logic            valid_out,
    output logic            sync_out,
    output logic [CH_W-1:0] chan_idx,
    output logic            seed_loaded,
    output logic            seed_pending
);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CHAN - 1);

    logic [31:0]     r_seed_q1;
    logic [31:0]     r_seed_q2;
    logic [31:0]     r_loaded_seed;
    logic [31:0]     r_pending_seed;
    logic            r_seed_pending;
    logic            r_seed_loaded;
    logic [31:0]     r_lfsr;
    logic            r_valid;
    logic            r_sync;
    logic [CH_W-1:0] r_chan;

    logic            w_qualify;
    logic            w_load;
    logic [31:0]     w_seed_eff;
    logic [31:0]     w_lfsr_step;

    // A seed counts only once it has been stable across both capture stages.
    assign w_qualify   = (r_seed_q1 == r_seed_q2) && (r_seed_q2 != r_loaded_seed);
    assign w_load      = sync_in && r_seed_pending;
    assign w_seed_eff  = (r_pending_seed == 32'h0) ? 32'h00000001 : r_pending_seed;
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAP_MASK : 32'h0);

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_seed_q1 <= 32'h0;
            r_seed_q2 <= 32'h0;
        end else begin
            r_seed_q1 <= seed_data;
            r_seed_q2 <= r_seed_q1;
        end
    end

    // A load wins over a same-cycle qualification; the newer seed re-qualifies next cycle.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_loaded_seed  <= 32'h0;
            r_pending_seed <= 32'h0;
            r_seed_pending <= 1'b0;
            r_seed_loaded  <= 1'b0;
        end else begin
            r_seed_loaded <= w_load;
            if (w_load) begin
                r_loaded_seed  <= r_pending_seed;
                r_seed_pending <= 1'b0;
            end else if (w_qualify) begin
                r_pending_seed <= r_seed_q2;
                r_seed_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_lfsr <= 32'h00000001;
        end else if (w_load) begin
            r_lfsr <= w_seed_eff;
        end else if (en) begin
            r_lfsr <= w_lfsr_step;
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
            r_chan  <= '0;
        end else begin
            r_valid <= en;
            r_sync  <= sync_in;
            if (sync_in || (r_chan == CH_LAST)) begin
                r_chan <= '0;
            end else begin
                r_chan <= r_chan + CH_W'(1);
            end
        end
    end

    assign noise_out    = r_lfsr[7:0];
    assign valid_out    = r_valid;
    assign sync_out     = r_sync;
    assign chan_idx     = r_chan;
    assign seed_loaded  = r_seed_loaded;
    assign seed_pending = r_seed_pending;

endmodule

// File: tb/tb_roachf_2048ch_seed_noise_gen.sv
// tb/tb_roachf_2048ch_seed_noise_gen.sv - scoreboard bench for the seeded LFSR noise source
module tb_roachf_2048ch_seed_noise_gen;

    localparam int N_CHAN = 2048;
    localparam int CH_W   = 11;

    logic            clk = 1'b0;
    logic            user_rst_n = 1'b0;
    logic [31:0]     seed_data = 32'h0;
    logic            sync_in = 1'b0;
    logic            en = 1'b0;
    logic [7:0]      noise_out;
    logic            valid_out;
    logic            sync_out;
    logic [CH_W-1:0] chan_idx;
    logic            seed_loaded;
    logic            seed_pending;

    roachf_2048ch_seed_noise_gen #(
        .N_CHAN  (N_CHAN),
        .CH_W    (CH_W),
        .TAP_MASK(32'h80200003)
    ) dut (
        .user_clk    (clk),
        .user_rst_n  (user_rst_n),
        .seed_data   (seed_data),
        .sync_in     (sync_in),
        .en          (en),
        .noise_out   (noise_out),
        .valid_out   (valid_out),
        .sync_out    (sync_out),
        .chan_idx    (chan_idx),
        .seed_loaded (seed_loaded),
        .seed_pending(seed_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  noise;
        logic        valid;
        logic        sync;
        int          chan;
        logic        loaded;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: software seed history, seed bookkeeping and the noise register.
    logic [31:0] seed_hist[$];
    logic [31:0] m_loaded, m_pend_val, m_lfsr;
    logic        m_pend;
    int          m_chan;

    function automatic logic [31:0] galois(input logic [31:0] v);
        logic [31:0] nv;
        nv = v / 2;
        if (v % 2 == 1) nv = nv ^ 32'h80200003;
        return nv;
    endfunction

    task automatic drive(input bit rst_n_v, input logic [31:0] s, input bit sy, input bit e);
        exp_t x;
        bit   stable_new;
        bit   do_load;
        @(negedge clk);
        user_rst_n = rst_n_v;
        seed_data  = s;
        sync_in    = sy;
        en         = e;
        if (!rst_n_v) begin
            seed_hist  = '{32'h0, 32'h0};
            m_loaded   = 32'h0;
            m_pend_val = 32'h0;
            m_pend     = 1'b0;
            m_lfsr     = 32'h1;
            m_chan     = 0;
            x.loaded   = 1'b0;
            x.valid    = 1'b0;
            x.sync     = 1'b0;
        end else begin
            stable_new = (seed_hist[0] == seed_hist[1]) && (seed_hist[1] != m_loaded);
            do_load    = sy && m_pend;
            if (do_load) begin
                m_lfsr   = (m_pend_val == 0) ? 32'h1 : m_pend_val;
                m_loaded = m_pend_val;
                m_pend   = 1'b0;
            end else begin
                if (stable_new) begin
                    m_pend_val = seed_hist[1];
                    m_pend     = 1'b1;
                end
                if (e) m_lfsr = galois(m_lfsr);
            end
            m_chan   = sy ? 0 : (m_chan + 1) % N_CHAN;
            x.loaded = do_load;
            x.valid  = e;
            x.sync   = sy;
            seed_hist.push_front(s);
            seed_hist = seed_hist[0:1];
        end
        x.noise = m_lfsr[7:0];
        x.chan  = m_chan;
        x.pend  = m_pend;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input logic [31:0] s, input bit e);
        for (int i = 0; i < n; i++) drive(1'b1, s, 1'b0, e);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (noise_out !== x.noise) begin
                    miscompares++;
                    $display("FAIL noise_out @%0t: got %h want %h", $time, noise_out, x.noise);
                end
                if (valid_out !== x.valid) begin
                    miscompares++;
                    $display("FAIL valid_out @%0t: got %b want %b", $time, valid_out, x.valid);
                end
                if (sync_out !== x.sync) begin
                    miscompares++;
                    $display("FAIL sync_out @%0t: got %b want %b", $time, sync_out, x.sync);
                end
                if (chan_idx !== CH_W'(x.chan)) begin
                    miscompares++;
                    $display("FAIL chan_idx @%0t: got %0d want %0d", $time, chan_idx, x.chan);
                end
                if (seed_loaded !== x.loaded) begin
                    miscompares++;
                    $display("FAIL seed_loaded @%0t: got %b want %b", $time, seed_loaded, x.loaded);
                end
                if (seed_pending !== x.pend) begin
                    miscompares++;
                    $display("FAIL seed_pending @%0t: got %b want %b", $time, seed_pending, x.pend);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] s;
        seed_hist = '{32'h0, 32'h0};
        m_loaded = 0; m_pend_val = 0; m_pend = 0; m_lfsr = 32'h1; m_chan = 0;

        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b1);
        // free-running noise and channel wrap past 2047
        run(2100, 32'h0, 1'b1);

        run(5, 32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        run(5, 32'hDEADBEEF, 1'b1);

        run(5, 32'h12345678, 1'b1);
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        run(3, 32'h12345678, 1'b1);
        run(5, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b1, 1'b1);
        run(3, 32'h0, 1'b1);

        for (int i = 0; i < 10000; i++) drive(1'b1, 32'hA5A5A5A5, 1'b1, $urandom_range(0, 3) != 0);

        run(6, 32'h1, 1'b1);
        drive(1'b1, 32'h1, 1'b1, 1'b1);
        run(6, 32'h1, 1'b1);
        run(2, 32'h2, 1'b1);
        drive(1'b1, 32'h2, 1'b1, 1'b1);
        run(4, 32'h2, 1'b1);
        drive(1'b1, 32'h2, 1'b1, 1'b1);
        drive(1'b1, 32'h2, 1'b1, 1'b1);
        run(3, 32'h2, 1'b1);

        run(4, 32'h2, 1'b0);
        run(2, 32'h2, 1'b1);

        // a seed changing every cycle must never qualify
        for (int i = 0; i < 30; i++) drive(1'b1, $urandom, (i % 7) == 3, 1'b1);

        run(6, 32'h00000077, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        run(8, 32'h0, 1'b1);
        drive(1'b1, 32'h0, 1'b1, 1'b1);
        run(3, 32'h0, 1'b1);

        s = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) s = $urandom;
            if ($urandom_range(0, 63) == 0) s = 32'h0;
            drive($urandom_range(0, 499) != 0, ($urandom_range(0, 31) == 0) ? $urandom : s,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0);
        end

        @(negedge clk);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
